chorus_sample_sequencer: RTL and testbench



---
 rtl/chorus_sample_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_chorus_sample_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chorus_sample_sequencer.sv
// rtl/chorus_sample_sequencer.sv - per-sample sequencer for the chorus DSP chain
//
// Purpose:
//   Each dry-sample strobe runs one fixed sequence through the chain:
//   LFO step, delay-buffer write, delay-buffer read, mixer start, output strobe.
//   The user settings are captured at the sample boundary so they stay fixed
//   for the whole sequence. A sample that arrives while busy is dropped and
//   flagged. A stage that waits too long on its handshake is aborted and
//   flagged. Both flags are sticky.
//
// Ports:
//   clk_i, reset_i                        clock, synchronous active-high reset
//   pktInChanged_i                        new dry sample strobe
//   lfoDone_i, bufRdValid_i, mixDone_i    stage completion handshakes
//   clearErr_i                            clears the sticky error flags
//   freqSetting_i/scaleFactor_i/mixSetting_i   raw settings
//   lfoStep_o, bufWr_o, bufRd_o, mixStart_o, pktOutChanged_o   stage pulses
//   freqSetting_o/scaleFactor_o/mixSetting_o   latched settings
//   busy_o, overrun_o, timeout_o, error_o      status

module chorus_sample_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pktInChanged_i,
    input  logic       lfoDone_i,
    input  logic       bufRdValid_i,
    input  logic       mixDone_i,
    input  logic       clearErr_i,
    input  logic [3:0] freqSetting_i,
    input  logic [3:0] scaleFactor_i,
    input  logic [3:0] mixSetting_i,
    output logic       lfoStep_o,
    output logic       bufWr_o,
    output logic       bufRd_o,
    output logic       mixStart_o,
    output logic       pktOutChanged_o,
    output logic [3:0] freqSetting_o,
    output logic [3:0] scaleFactor_o,
    output logic [3:0] mixSetting_o,
    output logic       busy_o,
    output logic       overrun_o,
    output logic       timeout_o,
    output logic       error_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LFO,
        S_WR,
        S_RD,
        S_MIX,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lfo_step;
    logic             r_buf_wr;
    logic             r_buf_rd;
    logic             r_mix_start;
    logic             r_pkt_out;
    logic             r_busy;
    logic             r_overrun;
    logic             r_timeout;
    logic             r_error;
    logic [3:0]       r_freq;
    logic [3:0]       r_scale;
    logic [3:0]       r_mix;

    logic             w_waiting;
    logic             w_stall;
    logic             w_overrun_set;
    logic             w_overrun_nxt;
    logic             w_timeout_nxt;

    // A wait state whose handshake is still low this cycle. A handshake that
    // lands on the terminal-count cycle clears w_waiting, so it beats the abort.
    always_comb begin
        w_waiting = 1'b0;
        case (r_state)
            S_LFO:   w_waiting = !lfoDone_i;
            S_RD:    w_waiting = !bufRdValid_i;
            S_MIX:   w_waiting = !mixDone_i;
            default: w_waiting = 1'b0;
        endcase
    end

    assign w_stall       = w_waiting && (r_cnt == TERM_CNT);
    assign w_overrun_set = pktInChanged_i && (r_state != S_IDLE);

    // Set beats clear when both happen on the same cycle.
    assign w_overrun_nxt = w_overrun_set || (r_overrun && !clearErr_i);
    assign w_timeout_nxt = w_stall       || (r_timeout && !clearErr_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_lfo_step  <= 1'b0;
            r_buf_wr    <= 1'b0;
            r_buf_rd    <= 1'b0;
            r_mix_start <= 1'b0;
            r_pkt_out   <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
            r_error     <= 1'b0;
            r_freq      <= '0;
            r_scale     <= '0;
            r_mix       <= '0;
        end else begin
            // Stage pulses are one cycle wide: raised only on the transition.
            r_lfo_step  <= 1'b0;
            r_buf_wr    <= 1'b0;
            r_buf_rd    <= 1'b0;
            r_mix_start <= 1'b0;
            r_pkt_out   <= 1'b0;
            r_overrun   <= w_overrun_nxt;
            r_timeout   <= w_timeout_nxt;
            r_error     <= w_overrun_nxt || w_timeout_nxt;

            case (r_state)
                S_IDLE: begin
                    if (pktInChanged_i) begin
                        r_freq     <= freqSetting_i;
                        r_scale    <= scaleFactor_i;
                        r_mix      <= mixSetting_i;
                        r_cnt      <= '0;
                        r_lfo_step <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_LFO;
                    end
                end
                S_LFO: begin
                    if (lfoDone_i) begin
                        r_buf_wr <= 1'b1;
                        r_state  <= S_WR;
                    end else if (w_stall) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WR: begin
                    r_cnt    <= '0;
                    r_buf_rd <= 1'b1;
                    r_state  <= S_RD;
                end
                S_RD: begin
                    if (bufRdValid_i) begin
                        r_cnt       <= '0;
                        r_mix_start <= 1'b1;
                        r_state     <= S_MIX;
                    end else if (w_stall) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_MIX: begin
                    if (mixDone_i) begin
                        r_pkt_out <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (w_stall) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign lfoStep_o       = r_lfo_step;
    assign bufWr_o         = r_buf_wr;
    assign bufRd_o         = r_buf_rd;
    assign mixStart_o      = r_mix_start;
    assign pktOutChanged_o = r_pkt_out;
    assign freqSetting_o   = r_freq;
    assign scaleFactor_o   = r_scale;
    assign mixSetting_o    = r_mix;
    assign busy_o          = r_busy;
    assign overrun_o       = r_overrun;
    assign timeout_o       = r_timeout;
    assign error_o         = r_error;

endmodule

// File: tb/tb_chorus_sample_sequencer.sv
// tb/tb_chorus_sample_sequencer.sv - directed self-checking bench for chorus_sample_sequencer

module tb_chorus_sample_sequencer;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       pktInChanged_i;
    logic       lfoDone_i;
    logic       bufRdValid_i;
    logic       mixDone_i;
    logic       clearErr_i;
    logic [3:0] freqSetting_i;
    logic [3:0] scaleFactor_i;
    logic [3:0] mixSetting_i;
    logic       lfoStep_o;
    logic       bufWr_o;
    logic       bufRd_o;
    logic       mixStart_o;
    logic       pktOutChanged_o;
    logic [3:0] freqSetting_o;
    logic [3:0] scaleFactor_o;
    logic [3:0] mixSetting_o;
    logic       busy_o;
    logic       overrun_o;
    logic       timeout_o;
    logic       error_o;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt;
    int pulse_cyc;
    int rd_cyc;
    int to_cyc;

    chorus_sample_sequencer #(
        .TIMEOUT_CYCLES(64),
        .CNT_W(7)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .pktInChanged_i(pktInChanged_i),
        .lfoDone_i(lfoDone_i),
        .bufRdValid_i(bufRdValid_i),
        .mixDone_i(mixDone_i),
        .clearErr_i(clearErr_i),
        .freqSetting_i(freqSetting_i),
        .scaleFactor_i(scaleFactor_i),
        .mixSetting_i(mixSetting_i),
        .lfoStep_o(lfoStep_o),
        .bufWr_o(bufWr_o),
        .bufRd_o(bufRd_o),
        .mixStart_o(mixStart_o),
        .pktOutChanged_o(pktOutChanged_o),
        .freqSetting_o(freqSetting_o),
        .scaleFactor_o(scaleFactor_o),
        .mixSetting_o(mixSetting_o),
        .busy_o(busy_o),
        .overrun_o(overrun_o),
        .timeout_o(timeout_o),
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    // {lfoStep, bufWr, bufRd, mixStart, pktOut, busy}
    wire [5:0]  w_seq = {lfoStep_o, bufWr_o, bufRd_o, mixStart_o, pktOutChanged_o, busy_o};
    wire [20:0] w_all = {w_seq[5:1], busy_o, overrun_o, timeout_o, error_o,
                         freqSetting_o, scaleFactor_o, mixSetting_o};

    // Advance to the next cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_i        = 1'b1;
        pktInChanged_i = 1'b0;
        lfoDone_i      = 1'b0;
        bufRdValid_i   = 1'b0;
        mixDone_i      = 1'b0;
        clearErr_i     = 1'b0;
        freqSetting_i  = 4'h0;
        scaleFactor_i  = 4'h0;
        mixSetting_i   = 4'h0;
        tick();
        tick();
        check("reset_all_outputs", 32'(w_all), 32'h0);
        reset_i = 1'b0;
        tick();

        // Single sample, all handshakes tied high.
        lfoDone_i = 1'b1; bufRdValid_i = 1'b1; mixDone_i = 1'b1;
        freqSetting_i = 4'h1; scaleFactor_i = 4'h2; mixSetting_i = 4'h3;
        pktInChanged_i = 1'b1;
        tick();
        pktInChanged_i = 1'b0;
        freqSetting_i = 4'hF; scaleFactor_i = 4'hF; mixSetting_i = 4'hF;
        check("c1_seq", 32'(w_seq), 32'b100001);
        check("c1_settings", {20'h0, freqSetting_o, scaleFactor_o, mixSetting_o}, 32'h123);
        tick();
        check("c2_seq", 32'(w_seq), 32'b010001);
        tick();
        check("c3_seq", 32'(w_seq), 32'b001001);
        tick();
        check("c4_seq", 32'(w_seq), 32'b000101);
        tick();
        check("c5_seq", 32'(w_seq), 32'b000011);
        tick();
        check("c6_seq", 32'(w_seq), 32'b000000);
        check("c6_error", 32'(error_o), 32'h0);
        check("c6_settings_hold", {20'h0, freqSetting_o, scaleFactor_o, mixSetting_o}, 32'h123);

        // Delayed stages: lfoDone in cycle 4, mixDone in cycle 17 -> pktOut in cycle 18.
        lfoDone_i = 1'b0; mixDone_i = 1'b0; bufRdValid_i = 1'b1;
        pktInChanged_i = 1'b1;
        pulse_cnt = 0; pulse_cyc = -1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            pktInChanged_i = 1'b0;
            if (pktOutChanged_o) begin
                pulse_cnt++;
                pulse_cyc = c;
            end
            lfoDone_i = (c == 4);
            mixDone_i = (c == 17);
        end
        check("delay_pkt_cycle", 32'(pulse_cyc), 32'd18);
        check("delay_pkt_count", 32'(pulse_cnt), 32'd1);
        check("delay_no_error", {29'h0, overrun_o, timeout_o, error_o}, 32'h0);

        // Stall in RD: bufRdValid never arrives.
        lfoDone_i = 1'b1; bufRdValid_i = 1'b0; mixDone_i = 1'b1;
        pktInChanged_i = 1'b1;
        pulse_cnt = 0; rd_cyc = -1; to_cyc = -1;
        for (int c = 1; c <= 75; c++) begin
            tick();
            pktInChanged_i = 1'b0;
            if (bufRd_o && rd_cyc < 0) rd_cyc = c;
            if (timeout_o && to_cyc < 0) to_cyc = c;
            if (pktOutChanged_o) pulse_cnt++;
        end
        check("stall_rd_cycle", 32'(rd_cyc), 32'd3);
        check("stall_timeout_cycle", 32'(to_cyc), 32'd67);
        check("stall_no_pkt", 32'(pulse_cnt), 32'd0);
        check("stall_idle", {30'h0, busy_o, error_o}, 32'h1);

        // Next strobe after a timeout sequences normally.
        bufRdValid_i = 1'b1;
        pktInChanged_i = 1'b1;
        pulse_cnt = 0; pulse_cyc = -1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            pktInChanged_i = 1'b0;
            if (pktOutChanged_o) begin
                pulse_cnt++;
                pulse_cyc = c;
            end
        end
        check("post_stall_pkt_cycle", 32'(pulse_cyc), 32'd5);
        check("post_stall_pkt_count", 32'(pulse_cnt), 32'd1);

        // Overrun: second strobe in cycle 2, inputs change to 2/3.
        freqSetting_i = 4'h5; scaleFactor_i = 4'h9; mixSetting_i = 4'h7;
        pktInChanged_i = 1'b1;
        pulse_cnt = 0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            freqSetting_i = 4'h2; scaleFactor_i = 4'h3;
            pktInChanged_i = (c == 2);
            if (pktOutChanged_o) pulse_cnt++;
        end
        check("overrun_flag", 32'(overrun_o), 32'h1);
        check("overrun_pkt_count", 32'(pulse_cnt), 32'd1);
        check("overrun_settings", {20'h0, freqSetting_o, scaleFactor_o, mixSetting_o}, 32'h597);

        // Clear alone with both flags set.
        check("pre_clear_flags", {29'h0, overrun_o, timeout_o, error_o}, 32'h7);
        clearErr_i = 1'b1;
        tick();
        clearErr_i = 1'b0;
        check("clear_alone_flags", {29'h0, overrun_o, timeout_o, error_o}, 32'h0);

        // Clear on the same cycle as a fresh overrun: set wins.
        pktInChanged_i = 1'b1;
        tick();
        clearErr_i = 1'b1;
        tick();
        pktInChanged_i = 1'b0;
        clearErr_i = 1'b0;
        check("clear_vs_set", {30'h0, overrun_o, error_o}, 32'h3);
        for (int c = 0; c < 6; c++) tick();

        // Reset in MIX.
        lfoDone_i = 1'b1; bufRdValid_i = 1'b1; mixDone_i = 1'b0;
        freqSetting_i = 4'hA; scaleFactor_i = 4'hB; mixSetting_i = 4'hC;
        pktInChanged_i = 1'b1;
        tick();
        pktInChanged_i = 1'b0;
        tick();
        tick();
        tick();
        check("pre_reset_in_mix", 32'(w_seq), 32'b000101);
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("reset_mid_all_outputs", 32'(w_all), 32'h0);
        mixDone_i = 1'b1;
        pulse_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (pktOutChanged_o || busy_o) pulse_cnt++;
        end
        check("late_mixdone_ignored", 32'(pulse_cnt), 32'd0);

        freqSetting_i = 4'h6; scaleFactor_i = 4'h4; mixSetting_i = 4'h8;
        pktInChanged_i = 1'b1;
        pulse_cnt = 0; pulse_cyc = -1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            pktInChanged_i = 1'b0;
            if (pktOutChanged_o) begin
                pulse_cnt++;
                pulse_cyc = c;
            end
        end
        check("post_reset_pkt_cycle", 32'(pulse_cyc), 32'd5);
        check("post_reset_settings", {20'h0, freqSetting_o, scaleFactor_o, mixSetting_o}, 32'h648);
        check("post_reset_flags", {29'h0, overrun_o, timeout_o, error_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
